// File: rtl/commit_pkg.sv
// Shared types and helpers for the 2-wide ROB commit stage.
package commit_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int IDX_W     = 5;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        RECOV = 1'b1
    } state_e;

    typedef struct packed {
        logic              vld;
        logic              done;
        logic              rd_en;
        logic [4:0]        rdl;
        logic [DATA_W-1:0] val;
        logic              mis;
        logic [DATA_W-1:0] tgt;
    } head_ent_t;

    // ROB entry k lives in the upper half of the physical tag space
    function automatic logic [TAG_W-1:0] idx2tag(input logic [IDX_W-1:0] idx);
        return {1'b1, idx};
    endfunction

endpackage

// File: rtl/commit_slot_chk.sv
// One retire slot: eligibility, ARF write qualification and latest-mapping compare.
module commit_slot_chk
    import commit_pkg::*;
(
    input  logic             en_i,
    input  logic             vld_i,
    input  logic             done_i,
    input  logic             rd_en_i,
    input  logic [4:0]       rdl_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] rdp_i,
    output logic             ret_o,
    output logic             we_o,
    output logic             clr_o
);

    assign ret_o = en_i & vld_i & done_i;
    // Logical register 0 is hardwired, never written
    assign we_o  = ret_o & rd_en_i & (rdl_i != 5'd0);
    assign clr_o = ret_o & rd_en_i & (rdp_i == idx2tag(idx_i));

endmodule

// File: rtl/rob_commit_2.sv
// 2-wide in-order retire controller at the ROB head with mispredict recovery.
// Optional COMMIT_STATS_EN adds retire/mispredict counters stat_ret/stat_mis.
module rob_commit_2
    import commit_pkg::*;
#(
    parameter int DW             = DATA_W,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hd0_vld,
    input  logic          hd1_vld,
    input  logic          hd0_done,
    input  logic          hd1_done,
    input  logic          hd0_rd_en,
    input  logic          hd1_rd_en,
    input  logic [4:0]    hd0_rdl,
    input  logic [4:0]    hd1_rdl,
    input  logic [DW-1:0] hd0_val,
    input  logic [DW-1:0] hd1_val,
    input  logic          hd0_mis,
    input  logic          hd1_mis,
    input  logic [DW-1:0] hd0_tgt,
    input  logic [DW-1:0] hd1_tgt,
    output logic [4:0]    rd1l_c,
    output logic [4:0]    rd2l_c,
    input  logic [5:0]    rd1p_c,
    input  logic [5:0]    rd2p_c,
    output logic [4:0]    head_ptr,
    output logic [1:0]    retire_num,
    output logic          arf_we1,
    output logic          arf_we2,
    output logic [4:0]    arf_wa1,
    output logic [4:0]    arf_wa2,
    output logic [DW-1:0] arf_wd1,
    output logic [DW-1:0] arf_wd2,
    output logic          map_clr1,
    output logic          map_clr2,
    output logic          recover,
    output logic          redir_vld,
    output logic [DW-1:0] redir_pc
`ifdef COMMIT_STATS_EN
    ,
    output logic [31:0]   stat_ret,
    output logic [31:0]   stat_mis
`endif
);

    head_ent_t ent0_s, ent1_s;
    logic      ret0_s, ret1_s, we0_s, we1_s, clr0_s, clr1_s;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [4:0]    head_q, head_d;
    logic [1:0]    ret_num_q, ret_num_d;
    logic          we1_q, we1_d, we2_q, we2_d;
    logic [4:0]    wa1_q, wa1_d, wa2_q, wa2_d;
    logic [DW-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
    logic          clr1_q, clr1_d, clr2_q, clr2_d;
    logic          recover_q, recover_d, redir_vld_q, redir_vld_d;
    logic [DW-1:0] redir_pc_q, redir_pc_d;

    assign ent0_s = {hd0_vld, hd0_done, hd0_rd_en, hd0_rdl, hd0_val, hd0_mis, hd0_tgt};
    assign ent1_s = {hd1_vld, hd1_done, hd1_rd_en, hd1_rdl, hd1_val, hd1_mis, hd1_tgt};

    assign rd1l_c = hd0_rdl;
    assign rd2l_c = hd1_rdl;

    commit_slot_chk u_slot0 (
        .en_i    (state_q == RUN),
        .vld_i   (ent0_s.vld),
        .done_i  (ent0_s.done),
        .rd_en_i (ent0_s.rd_en),
        .rdl_i   (ent0_s.rdl),
        .idx_i   (head_q),
        .rdp_i   (rd1p_c),
        .ret_o   (ret0_s),
        .we_o    (we0_s),
        .clr_o   (clr0_s)
    );

    // Slot 1 never overtakes a mispredicted slot 0
    commit_slot_chk u_slot1 (
        .en_i    (ret0_s & ~ent0_s.mis),
        .vld_i   (ent1_s.vld),
        .done_i  (ent1_s.done),
        .rd_en_i (ent1_s.rd_en),
        .rdl_i   (ent1_s.rdl),
        .idx_i   (head_q + 5'd1),
        .rdp_i   (rd2p_c),
        .ret_o   (ret1_s),
        .we_o    (we1_s),
        .clr_o   (clr1_s)
    );

    // Next-state and next-output computation for retire and recovery
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        head_d      = head_q + {4'd0, ret0_s} + {4'd0, ret1_s};
        ret_num_d   = {1'b0, ret0_s} + {1'b0, ret1_s};
        we1_d       = we0_s & ~(we1_s & (ent0_s.rdl == ent1_s.rdl));
        we2_d       = we1_s;
        wa1_d       = ent0_s.rdl;
        wa2_d       = ent1_s.rdl;
        wd1_d       = ent0_s.val;
        wd2_d       = ent1_s.val;
        clr1_d      = clr0_s;
        clr2_d      = clr1_s;
        recover_d   = 1'b0;
        redir_vld_d = 1'b0;
        redir_pc_d  = redir_pc_q;
        case (state_q)
            RUN: begin
                if (ret1_s & ent1_s.mis) begin
                    state_d     = RECOV;
                    cnt_d       = 2'(RECOVER_CYCLES - 1);
                    recover_d   = 1'b1;
                    redir_vld_d = 1'b1;
                    redir_pc_d  = ent1_s.tgt;
                end else if (ret0_s & ~ret1_s & ent0_s.mis) begin
                    state_d     = RECOV;
                    cnt_d       = 2'(RECOVER_CYCLES - 1);
                    recover_d   = 1'b1;
                    redir_vld_d = 1'b1;
                    redir_pc_d  = ent0_s.tgt;
                end else begin
                    state_d = RUN;
                end
            end
            RECOV: begin
                if (cnt_q == 2'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d     = cnt_q - 2'd1;
                    recover_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            cnt_q       <= 2'd0;
            head_q      <= 5'd0;
            ret_num_q   <= 2'd0;
            we1_q       <= 1'b0;
            we2_q       <= 1'b0;
            wa1_q       <= 5'd0;
            wa2_q       <= 5'd0;
            wd1_q       <= '0;
            wd2_q       <= '0;
            clr1_q      <= 1'b0;
            clr2_q      <= 1'b0;
            recover_q   <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            head_q      <= head_d;
            ret_num_q   <= ret_num_d;
            we1_q       <= we1_d;
            we2_q       <= we2_d;
            wa1_q       <= wa1_d;
            wa2_q       <= wa2_d;
            wd1_q       <= wd1_d;
            wd2_q       <= wd2_d;
            clr1_q      <= clr1_d;
            clr2_q      <= clr2_d;
            recover_q   <= recover_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign head_ptr   = head_q;
    assign retire_num = ret_num_q;
    assign arf_we1    = we1_q;
    assign arf_we2    = we2_q;
    assign arf_wa1    = wa1_q;
    assign arf_wa2    = wa2_q;
    assign arf_wd1    = wd1_q;
    assign arf_wd2    = wd2_q;
    assign map_clr1   = clr1_q;
    assign map_clr2   = clr2_q;
    assign recover    = recover_q;
    assign redir_vld  = redir_vld_q;
    assign redir_pc   = redir_pc_q;

`ifdef COMMIT_STATS_EN
    logic [31:0] stat_ret_q, stat_mis_q;

    // Retirement and mispredict counters, wrapping naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_ret_q <= 32'd0;
            stat_mis_q <= 32'd0;
        end else begin
            stat_ret_q <= stat_ret_q + {30'd0, ret_num_q};
            stat_mis_q <= stat_mis_q + {31'd0, redir_vld_q};
        end
    end

    assign stat_ret = stat_ret_q;
    assign stat_mis = stat_mis_q;
`endif

endmodule
